// File: rtl/i2c_reg_sequencer.sv
// Purpose: runs single-byte I2C register reads/writes by driving the master's start/send handshake.
// Latency: a command takes as long as the bus transfer; the response pulses one cycle after the master goes idle.
// Backpressure: one command in flight; cmd_ready only while idle and the master reports ready.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_rw (1=read), cmd_dev, cmd_reg, cmd_wdata
//   rsp_valid               one-cycle completion pulse with rsp_rdata and rsp_err (0 OK, 1 NACK/abort, 2 timeout)
//   m_start/m_send/m_receive/m_datasend   controls to the I2C master
//   m_ready/m_sended/m_received/m_datareceive   status from the I2C master
module i2c_reg_sequencer #(
  parameter int                   TIMEOUT_W = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       m_start,
  input  logic       m_ready,
  output logic       m_send,
  output logic       m_receive,
  output logic [7:0] m_datasend,
  input  logic       m_sended,
  input  logic [7:0] m_datareceive,
  input  logic       m_received
);

  localparam logic [3:0] ST_RST       = 4'd0;
  localparam logic [3:0] ST_IDLE      = 4'd1;
  localparam logic [3:0] ST_ADDR_W    = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_WDATA     = 4'd4;
  localparam logic [3:0] ST_ADDR_R    = 4'd5;
  localparam logic [3:0] ST_RDATA     = 4'd6;
  localparam logic [3:0] ST_WAIT_IDLE = 4'd7;
  localparam logic [3:0] ST_RESP      = 4'd8;

  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - WD_ONE;

  logic [3:0]           state;
  logic                 lat_rw;
  logic [6:0]           lat_dev;
  logic [7:0]           lat_reg;
  logic [7:0]           lat_wdata;
  logic                 sended_q;
  logic                 received_q;
  logic                 ready_q;
  logic                 busy_seen;
  logic [TIMEOUT_W-1:0] wdog;

  logic accept;
  logic sended_rise;
  logic received_rise;
  logic active;
  logic counting;
  logic abort;
  logic tmo_hit;

  assign cmd_ready     = (state == ST_IDLE) && m_ready;
  assign accept        = cmd_valid && cmd_ready;
  assign rsp_valid     = (state == ST_RESP);
  assign sended_rise   = m_sended && !sended_q;
  assign received_rise = m_received && !received_q;
  assign active        = (state == ST_ADDR_W) || (state == ST_REG) || (state == ST_WDATA) ||
                         (state == ST_ADDR_R) || (state == ST_RDATA);
  assign counting      = active || (state == ST_WAIT_IDLE);
  // Master idle again only counts as an abort once it has actually left idle for this
  // command; a rise that coincides with the master going idle is also an abort.
  assign abort         = active && m_ready && (busy_seen || sended_rise);
  assign tmo_hit       = counting && (wdog == WD_LAST);

  // Single-byte reads only: the master must NACK the one data byte.
  assign m_receive     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RST;
      lat_rw     <= 1'b0;
      lat_dev    <= 7'd0;
      lat_reg    <= 8'd0;
      lat_wdata  <= 8'd0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_seen  <= 1'b0;
      wdog       <= '0;
      rsp_rdata  <= 8'd0;
      rsp_err    <= 2'd0;
      m_start    <= 1'b0;
      m_send     <= 1'b0;
      m_datasend <= 8'd0;
    end else begin
      sended_q   <= m_sended;
      received_q <= m_received;
      ready_q    <= m_ready;
      m_start    <= 1'b0;
      if (counting && (wdog != TIMEOUT)) wdog <= wdog + WD_ONE;
      if (active && !m_ready) busy_seen <= 1'b1;

      if (tmo_hit) begin
        rsp_err   <= 2'd2;
        rsp_rdata <= 8'd0;
        m_send    <= 1'b0;
        state     <= m_ready ? ST_RESP : ST_WAIT_IDLE;
      end else if (abort) begin
        rsp_err   <= 2'd1;
        rsp_rdata <= 8'd0;
        m_send    <= 1'b0;
        state     <= ST_RESP;
      end else begin
        case (state)
          ST_RST: state <= ST_IDLE;
          ST_IDLE: begin
            if (accept) begin
              lat_rw     <= cmd_rw;
              lat_dev    <= cmd_dev;
              lat_reg    <= cmd_reg;
              lat_wdata  <= cmd_wdata;
              wdog       <= '0;
              busy_seen  <= 1'b0;
              rsp_err    <= 2'd0;
              rsp_rdata  <= 8'd0;
              m_datasend <= {cmd_dev, 1'b0};
              m_start    <= 1'b1;
              state      <= ST_ADDR_W;
            end
          end
          ST_ADDR_W: begin
            if (sended_rise) begin
              m_datasend <= lat_reg;
              m_send     <= 1'b1;
              state      <= ST_REG;
            end
          end
          ST_REG: begin
            if (sended_rise) begin
              if (lat_rw) begin
                // Start lands during the master's ACK wait, so it becomes a repeated start.
                m_send     <= 1'b0;
                m_datasend <= {lat_dev, 1'b1};
                m_start    <= 1'b1;
                state      <= ST_ADDR_R;
              end else begin
                m_datasend <= lat_wdata;
                state      <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (sended_rise) begin
              m_send  <= 1'b0;
              rsp_err <= 2'd0;
              state   <= ST_WAIT_IDLE;
            end
          end
          ST_ADDR_R: begin
            if (sended_rise) state <= ST_RDATA;
          end
          ST_RDATA: begin
            if (received_rise) begin
              rsp_rdata <= m_datareceive;
              rsp_err   <= 2'd0;
              state     <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (m_ready && !ready_q) state <= ST_RESP;
          end
          ST_RESP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Purpose: randomized scoreboard bench for i2c_reg_sequencer against a byte-level I2C master/slave model.
// Latency: responses are matched in order whenever rsp_valid is seen.
// Backpressure: commands are issued only while cmd_ready is high.
module tb_i2c_reg_sequencer;

  localparam int T        = 2000;
  localparam int EV_S     = 256;
  localparam int EV_SR    = 257;
  localparam int EV_P     = 258;
  localparam int EV_MNACK = 259;
  localparam int EV_MACK  = 260;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev = 7'd0;
  logic [7:0] cmd_reg = 8'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_start;
  logic       m_send;
  logic       m_receive;
  logic [7:0] m_datasend;
  logic       m_ready = 1'b1;
  logic       m_sended = 1'b0;
  logic       m_received = 1'b0;
  logic [7:0] m_datareceive = 8'd0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_W(20), .TIMEOUT(20'd2000)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_start(m_start), .m_ready(m_ready), .m_send(m_send), .m_receive(m_receive),
    .m_datasend(m_datasend), .m_sended(m_sended), .m_datareceive(m_datareceive),
    .m_received(m_received)
  );

  typedef struct {
    int err;
    int rdata;
    int n_ev;
    bit nosend;
  } exp_t;

  exp_t       exp_q[$];
  int         exp_bus[$];
  int         act_bus[$];
  logic [7:0] ref_mem[256];
  logic [7:0] slave_mem[256];
  int         cfg_nack = -1;
  bit         cfg_stall = 1'b0;
  int         n_checks = 0;
  int         n_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- I2C master + slave model (byte level) ----------------
  int         mph = 0;
  int         mcnt = 0;
  int         midx = 0;
  bit         m_rs, start_seen, after_sr, cur_addr;
  logic [7:0] cur, start_byte, ptr;

  initial begin
    cur = 8'd0; start_byte = 8'd0; ptr = 8'd0;
    start_seen = 1'b0; after_sr = 1'b0; cur_addr = 1'b0;
    forever begin
      @(posedge clk);
      m_rs = reset;
      @(negedge clk);
      if (m_rs) begin
        m_ready = 1'b1; m_sended = 1'b0; m_received = 1'b0; mph = 0;
        act_bus.delete();
      end else begin
        case (mph)
          0: if (m_start) begin
               act_bus.push_back(EV_S);
               cur = m_datasend; cur_addr = 1'b1; midx = 0; after_sr = 1'b0;
               m_ready = 1'b0;
               if (cfg_stall) mph = 6;
               else begin mph = 1; mcnt = $urandom_range(1, 5); end
             end
          1: if (mcnt > 0) mcnt--;
             else begin
               act_bus.push_back(int'(cur));
               if (midx == cfg_nack) begin mph = 5; mcnt = $urandom_range(1, 3); end
               else begin
                 if (midx == 1) ptr = cur;
                 if (midx == 2 && !after_sr) slave_mem[ptr] = cur;
                 m_sended = 1'b1; start_seen = 1'b0; mph = 2; mcnt = $urandom_range(1, 4);
               end
             end
          2: begin
               if (m_start) begin start_seen = 1'b1; start_byte = m_datasend; end
               if (mcnt > 0) mcnt--;
               else begin
                 m_sended = 1'b0;
                 if (start_seen) begin
                   act_bus.push_back(EV_SR);
                   cur = start_byte; cur_addr = 1'b1; after_sr = 1'b1; midx++;
                   mph = 1; mcnt = $urandom_range(1, 5);
                 end else if (cur_addr && cur[0]) begin
                   mph = 3; mcnt = $urandom_range(2, 6);
                 end else if (m_send) begin
                   cur = m_datasend; cur_addr = 1'b0; midx++;
                   mph = 1; mcnt = $urandom_range(1, 5);
                 end else begin
                   mph = 5; mcnt = $urandom_range(1, 3);
                 end
               end
             end
          3: if (mcnt > 0) mcnt--;
             else begin
               m_datareceive = slave_mem[ptr];
               m_received = 1'b1;
               act_bus.push_back(int'(m_datareceive));
               act_bus.push_back(m_receive ? EV_MACK : EV_MNACK);
               mph = 4; mcnt = $urandom_range(1, 3);
             end
          4: if (mcnt > 0) mcnt--;
             else begin m_received = 1'b0; mph = 5; mcnt = $urandom_range(1, 3); end
          5: if (mcnt > 0) mcnt--;
             else begin act_bus.push_back(EV_P); m_ready = 1'b1; mph = 0; end
          6: if (!cfg_stall) begin mph = 5; mcnt = 1; end
          default: mph = 0;
        endcase
      end
    end
  end

  // ---------------- reference model: expected bus trace and response ----------------
  task automatic build_exp(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input int nack, input bit stall);
    exp_t       e;
    int         ev[$];
    logic [7:0] b[3];
    e.err = 0; e.rdata = 0; e.nosend = 1'b0;
    b[0] = {dev, 1'b0};
    b[1] = rg;
    b[2] = rw ? {dev, 1'b1} : wd;
    ev.push_back(EV_S);
    if (stall) begin
      e.err = 2;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rw && i == 2) ev.push_back(EV_SR);
        ev.push_back(int'(b[i]));
        if (nack == i) begin e.err = 1; break; end
      end
      if (e.err == 0 && rw) begin
        ev.push_back(int'(ref_mem[rg]));
        ev.push_back(EV_MNACK);
        e.rdata = int'(ref_mem[rg]);
      end
      if (e.err == 0 && !rw) ref_mem[rg] = wd;
      e.nosend = (nack == 0);
    end
    ev.push_back(EV_P);
    e.n_ev = ev.size();
    foreach (ev[i]) exp_bus.push_back(ev[i]);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  bit   send_seen = 1'b0;
  int   nbad;
  int   ev_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) send_seen = 1'b0;
      if (m_send) send_seen = 1'b1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_err", rsp_err, mon_e.err);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("bus_len", act_bus.size(), mon_e.n_ev);
          nbad = 0;
          for (int i = 0; i < mon_e.n_ev; i++) begin
            ev_exp = exp_bus.pop_front();
            if (i >= act_bus.size() || act_bus[i] != ev_exp) nbad++;
          end
          check("bus_events_wrong", nbad, 0);
          if (mon_e.nosend) check("m_send_seen", send_seen, 0);
          act_bus.delete();
          send_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 5000) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 5000) begin @(negedge clk); k++; end
    check("rsp_pending", exp_q.size(), 0);
  endtask

  task automatic issue(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input int nack, input bit stall, input bit track);
    wait_ready();
    cfg_nack  = nack;
    cfg_stall = stall;
    if (track) build_exp(rw, dev, rg, wd, nack, stall);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge clk);
    check("accepted", cmd_ready, 0);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_m_start"}, m_start, 0);
    check({tag, "_m_send"}, m_send, 0);
    check({tag, "_m_receive"}, m_receive, 0);
    check({tag, "_m_datasend"}, m_datasend, 0);
  endtask

  initial begin
    logic [7:0] v;
    int         k;
    int         nk;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      slave_mem[i] = v;
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Directed: write, read, address NACK, reg NACK on read.
    issue(1'b0, 7'h50, 8'h10, 8'hA5, -1, 1'b0, 1'b1);
    slave_mem[8'h22] = 8'h3C;
    ref_mem[8'h22]   = 8'h3C;
    issue(1'b1, 7'h50, 8'h22, 8'h00, -1, 1'b0, 1'b1);
    issue(1'b0, 7'h50, 8'h11, 8'h77, 0, 1'b0, 1'b1);
    issue(1'b1, 7'h50, 8'h23, 8'h00, 1, 1'b0, 1'b1);

    // Timeout: master stalls after start.
    issue(1'b0, 7'h2A, 8'h05, 8'h99, -1, 1'b1, 1'b1);
    repeat (T - 1) @(negedge clk);
    check("tmo_err_before", rsp_err, 0);
    check("tmo_send_before", m_send, 0);
    @(negedge clk);
    check("tmo_err_at", rsp_err, 2);
    check("tmo_m_start", m_start, 0);
    check("tmo_m_send", m_send, 0);
    check("tmo_m_receive", m_receive, 0);
    repeat (5) @(negedge clk);
    check("tmo_cmd_ready_held", cmd_ready, 0);
    cfg_stall = 1'b0;
    wait_done();

    // Reset during the data phase of a read: no response, then a clean write.
    issue(1'b1, 7'h33, 8'h40, 8'h00, -1, 1'b0, 1'b0);
    k = 0;
    while (mph != 3 && k < 500) begin @(negedge clk); k++; end
    check("reached_rdata", mph, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    issue(1'b0, 7'h33, 8'h40, 8'h5C, -1, 1'b0, 1'b1);
    wait_done();

    // Randomized commands, occasional NACK at a random byte.
    for (int n = 0; n < 40; n++) begin
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      issue(1'($urandom), 7'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), nk, 1'b0, 1'b1);
    end
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_errs);
    $fatal(1, "global timeout");
  end

endmodule
